// File: rtl/rom_dn_writer_pkg.sv
// Shared types and memory-map constants for the ROM download writer
// and the download-side region decoder.
package rom_dn_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_WRITE,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [2:0] REG_A1   = 3'd0;
   localparam logic [2:0] REG_B1   = 3'd1;
   localparam logic [2:0] REG_C1   = 3'd2;
   localparam logic [2:0] REG_D1   = 3'd3;
   localparam logic [2:0] REG_K2   = 3'd4;
   localparam logic [2:0] REG_L3   = 3'd5;
   localparam logic [2:0] REG_NONE = 3'd7;

   localparam logic [13:0] BASE_A1 = 14'h0000;
   localparam logic [13:0] BASE_B1 = 14'h0800;
   localparam logic [13:0] BASE_C1 = 14'h1000;
   localparam logic [13:0] BASE_D1 = 14'h1800;
   localparam logic [13:0] BASE_K2 = 14'h2000;
   localparam logic [13:0] BASE_L3 = 14'h2800;

   localparam int IMAGE_BYTES_DEF = 10496;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational map of a download address onto the ROM it lands in:
// 2 KiB program/char windows, then a 256-byte PROM window, else unmapped.
module rom_region_decode
   import rom_dn_writer_pkg::*;
(
   input  logic [13:0] addr,
   output logic [2:0]  region
);

   always_comb begin
      region = REG_NONE;
      unique case (addr[13:11])
         BASE_A1[13:11]: region = REG_A1;
         BASE_B1[13:11]: region = REG_B1;
         BASE_C1[13:11]: region = REG_C1;
         BASE_D1[13:11]: region = REG_D1;
         BASE_K2[13:11]: region = REG_K2;
         // PROM only occupies the first 256 bytes of its 2 KiB window
         BASE_L3[13:11]: region = (addr[10:8] == BASE_L3[10:8]) ? REG_L3 : REG_NONE;
         default:        region = REG_NONE;
      endcase
   end

endmodule

// File: rtl/rom_dn_writer.sv
// Paced write master for the core ROM download port: one byte in over
// valid/ready, one single-cycle dn_wr out, then WR_GAP idle cycles.
module rom_dn_writer
   import rom_dn_writer_pkg::*;
#(
   parameter int IMAGE_BYTES = IMAGE_BYTES_DEF,
   parameter int WR_GAP      = 2,
   parameter int ADDR_W      = 14
) (
   input  logic              CLK_18M,
   input  logic              RESET_n,
   input  logic              start,
   input  logic              abort,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic [ADDR_W-1:0] dn_addr,
   output logic [7:0]        dn_data,
   output logic              dn_wr,
   output logic [2:0]        region,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [15:0]       checksum
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMAGE_BYTES - 1);
   localparam logic [3:0]        GAP_LOAD  = 4'(WR_GAP);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              wr_q, wr_d;
   logic [15:0]       sum_q, sum_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic [3:0]        gap_q, gap_d;
   logic              restart;
   logic              byte_end;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_d     = 1'b0;
      sum_d    = sum_q;
      done_d   = done_q;
      ovf_d    = ovf_q;
      gap_d    = gap_q;
      restart  = 1'b0;
      byte_end = 1'b0;

      if (abort) begin
         // The strobe already on the bus this cycle counts as written.
         state_d = ST_IDLE;
         if (state_q == ST_WRITE) begin
            sum_d = sum_q + {8'h00, data_q};
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               restart = start;
            end
            ST_ACCEPT: begin
               if (s_valid) begin
                  data_d  = s_data;
                  wr_d    = 1'b1;
                  state_d = ST_WRITE;
               end
            end
            ST_WRITE: begin
               sum_d = sum_q + {8'h00, data_q};
               if (WR_GAP > 0) begin
                  gap_d   = GAP_LOAD;
                  state_d = ST_GAP;
               end else begin
                  byte_end = 1'b1;
               end
            end
            ST_GAP: begin
               if (gap_q <= 4'd1) begin
                  byte_end = 1'b1;
               end else begin
                  gap_d = gap_q - 4'd1;
               end
            end
            ST_DONE: begin
               restart = start;
               if (!start && s_valid) begin
                  ovf_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (restart) begin
            addr_d  = '0;
            sum_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            state_d = ST_ACCEPT;
         end

         // Address stops at the last byte, so it can never wrap.
         if (byte_end) begin
            if (addr_q == LAST_ADDR) begin
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               state_d = ST_ACCEPT;
            end
         end
      end
   end

   always_ff @(posedge CLK_18M or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         sum_q   <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         sum_q   <= sum_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         gap_q   <= gap_d;
      end
   end

   assign s_ready  = (state_q == ST_ACCEPT);
   assign busy     = (state_q == ST_ACCEPT) || (state_q == ST_WRITE) || (state_q == ST_GAP);
   assign dn_addr  = addr_q;
   assign dn_data  = data_q;
   assign dn_wr    = wr_q;
   assign done     = done_q;
   assign overflow = ovf_q;
   assign checksum = sum_q;

   rom_region_decode u_region (
      .addr   (addr_q[13:0]),
      .region (region)
   );

endmodule
